// File: rtl/program_counter_address_unit_pkg.sv
// Address-select codes and 6502 vector addresses shared by the decoder and the PC/address unit.
package program_counter_address_unit_pkg;

  localparam logic [1:0] ADR_SEL_PC   = 2'd0;
  localparam logic [1:0] ADR_SEL_MEM  = 2'd1;
  localparam logic [1:0] ADR_SEL_ALU  = 2'd2;
  localparam logic [1:0] ADR_SEL_HOLD = 2'd3;

  localparam logic [15:0] VEC_NMI   = 16'hFFFA;
  localparam logic [15:0] VEC_RESET = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ   = 16'hFFFE;

endpackage

// File: rtl/program_counter_address_unit.sv
// Program counter and external address bus driver; runs the reset-vector fetch
// before releasing the decoder.
//
// state      | meaning
// VEC_LO     | driving RESET_VECTOR, capturing vector low byte
// VEC_HI     | driving RESET_VECTOR+1, loading PC from both vector bytes
// RUN        | normal operation, PC steps and address mux active
module program_counter_address_unit
  import program_counter_address_unit_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = VEC_RESET
) (
  input  logic        clk,
  input  logic        res,
  input  logic        rdy_in,
  input  logic        pc_enable,
  input  logic [1:0]  address_select,
  input  logic [15:0] memory_address,
  input  logic [7:0]  alu_result,
  input  logic [7:0]  data_in,
  input  logic        pc_load,
  input  logic [15:0] pc_load_value,
  output logic [15:0] address_out,
  output logic [15:0] pc_out,
  output logic        cpu_rdy,
  output logic        vector_busy
);

  typedef enum logic [1:0] {
    ST_VEC_LO = 2'd0,
    ST_VEC_HI = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  vec_lo_q, vec_lo_d;
  logic [15:0] addr_hold_q, addr_hold_d;
  logic [15:0] run_addr;

  // Zero-page indexed addresses never carry into the high byte.
  always_comb begin
    run_addr = pc_q;
    case (address_select)
      ADR_SEL_PC:   run_addr = pc_q;
      ADR_SEL_MEM:  run_addr = memory_address;
      ADR_SEL_ALU:  run_addr = {8'h00, alu_result};
      ADR_SEL_HOLD: run_addr = addr_hold_q;
      default:      run_addr = pc_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    vec_lo_d    = vec_lo_q;
    addr_hold_d = addr_hold_q;
    address_out = RESET_VECTOR;
    vector_busy = 1'b1;
    cpu_rdy     = 1'b0;
    case (state_q)
      ST_VEC_LO: begin
        address_out = RESET_VECTOR;
        if (rdy_in) begin
          vec_lo_d = data_in;
          state_d  = ST_VEC_HI;
        end
      end
      ST_VEC_HI: begin
        address_out = RESET_VECTOR + 16'd1;
        if (rdy_in) begin
          pc_d    = {data_in, vec_lo_q};
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        address_out = run_addr;
        vector_busy = 1'b0;
        cpu_rdy     = rdy_in;
        if (rdy_in) begin
          addr_hold_d = run_addr;
          if (pc_load) begin
            pc_d = pc_load_value;
          end else if (pc_enable) begin
            pc_d = pc_q + 16'd1;
          end
        end
      end
      default: state_d = ST_VEC_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q     <= ST_VEC_LO;
      pc_q        <= 16'h0000;
      vec_lo_q    <= 8'h00;
      addr_hold_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      vec_lo_q    <= vec_lo_d;
      addr_hold_q <= addr_hold_d;
    end
  end

  assign pc_out = pc_q;

endmodule

// File: tb/tb_program_counter_address_unit.sv
// Self-checking bench: directed scenarios plus random traffic against a
// phase-based reference model of the vector fetch and PC/address behaviour.
module tb_program_counter_address_unit;

  logic        clk;
  logic        res;
  logic        rdy_in;
  logic        pc_enable;
  logic [1:0]  address_select;
  logic [15:0] memory_address;
  logic [7:0]  alu_result;
  logic [7:0]  data_in;
  logic        pc_load;
  logic [15:0] pc_load_value;
  logic [15:0] address_out;
  logic [15:0] pc_out;
  logic        cpu_rdy;
  logic        vector_busy;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  vec_lo_byte = 8'h34;
  logic [7:0]  vec_hi_byte = 8'h12;

  // reference model: phase 0 = fetching low byte, 1 = high byte, 2 = running
  int          m_phase;
  logic [15:0] m_pc;
  logic [7:0]  m_lo;
  logic [15:0] m_hold;

  bit          c_en = 0;
  logic [15:0] c_addr = '0;

  program_counter_address_unit #(.RESET_VECTOR(16'hFFFC)) dut (
    .clk            (clk),
    .res            (res),
    .rdy_in         (rdy_in),
    .pc_enable      (pc_enable),
    .address_select (address_select),
    .memory_address (memory_address),
    .alu_result     (alu_result),
    .data_in        (data_in),
    .pc_load        (pc_load),
    .pc_load_value  (pc_load_value),
    .address_out    (address_out),
    .pc_out         (pc_out),
    .cpu_rdy        (cpu_rdy),
    .vector_busy    (vector_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_rd(input logic [15:0] a);
    if (a == 16'hFFFC) return vec_lo_byte;
    if (a == 16'hFFFD) return vec_hi_byte;
    return a[7:0] ^ a[15:8];
  endfunction

  always_comb data_in = mem_rd(address_out);

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic cycle(input bit r, input bit rdy, input bit en, input logic [1:0] sel,
                       input logic [15:0] madr, input logic [7:0] alu,
                       input bit ld, input logic [15:0] ldv);
    logic [15:0] e_addr;
    @(negedge clk);
    res = r; rdy_in = rdy; pc_enable = en; address_select = sel;
    memory_address = madr; alu_result = alu; pc_load = ld; pc_load_value = ldv;
    #1;
    if (m_phase == 0)      e_addr = 16'hFFFC;
    else if (m_phase == 1) e_addr = 16'hFFFD;
    else if (sel == 2'd0)  e_addr = m_pc;
    else if (sel == 2'd1)  e_addr = madr;
    else if (sel == 2'd2)  e_addr = 16'(alu);
    else                   e_addr = m_hold;
    chk("address_out", address_out, e_addr);
    chk("pc_out", pc_out, m_pc);
    chk("cpu_rdy", 16'(cpu_rdy), 16'((m_phase == 2) && rdy));
    chk("vector_busy", 16'(vector_busy), 16'(m_phase != 2));
    if (c_en) chk("addr_directed", address_out, c_addr);
    c_en = 0;
    if (r) begin
      m_phase = 0; m_pc = 16'h0000; m_lo = 8'h00; m_hold = 16'h0000;
    end else if (rdy) begin
      if (m_phase == 0) begin
        m_lo = mem_rd(e_addr);
        m_phase = 1;
      end else if (m_phase == 1) begin
        m_pc = 16'(int'(mem_rd(e_addr)) * 256 + int'(m_lo));
        m_phase = 2;
      end else begin
        m_hold = e_addr;
        if (ld)      m_pc = ldv;
        else if (en) m_pc = 16'((int'(m_pc) + 1) % 65536);
      end
    end
    @(posedge clk);
  endtask

  task automatic idle(input bit rdy, input bit en);
    cycle(1'b0, rdy, en, 2'd0, 16'h0000, 8'h00, 1'b0, 16'h0000);
  endtask

  initial begin
    res = 1'b1; rdy_in = 1'b1; pc_enable = 1'b0; address_select = 2'd0;
    memory_address = '0; alu_result = '0; pc_load = 1'b0; pc_load_value = '0;
    @(posedge clk);
    m_phase = 0; m_pc = 16'h0000; m_lo = 8'h00; m_hold = 16'h0000;

    // vector fetch: $FFFC then $FFFD, running at $1234 on cycle 3
    c_en = 1; c_addr = 16'hFFFC; idle(1'b1, 1'b0);
    c_en = 1; c_addr = 16'hFFFD; idle(1'b1, 1'b0);
    #1 chk("pc_vec", pc_out, 16'h1234);
    chk("cpu_rdy_run", 16'(cpu_rdy), 16'h0001);

    // three increments
    repeat (3) idle(1'b1, 1'b1);
    #1 chk("pc_inc3", pc_out, 16'h1237);

    // wrap $FFFF -> $0000
    cycle(1'b0, 1'b1, 1'b0, 2'd0, 16'h0000, 8'h00, 1'b1, 16'hFFFF);
    idle(1'b1, 1'b1);
    #1 chk("pc_wrap", pc_out, 16'h0000);

    // address select sequence
    cycle(1'b0, 1'b1, 1'b0, 2'd0, 16'h0042, 8'hF0, 1'b0, 16'h0000);
    c_en = 1; c_addr = 16'h0042;
    cycle(1'b0, 1'b1, 1'b0, 2'd1, 16'h0042, 8'hF0, 1'b0, 16'h0000);
    c_en = 1; c_addr = 16'h00F0;
    cycle(1'b0, 1'b1, 1'b0, 2'd2, 16'h0042, 8'hF0, 1'b0, 16'h0000);
    c_en = 1; c_addr = 16'h00F0;
    cycle(1'b0, 1'b1, 1'b0, 2'd3, 16'h0042, 8'hF0, 1'b0, 16'h0000);

    // load beats enable
    cycle(1'b0, 1'b1, 1'b1, 2'd0, 16'h0000, 8'h00, 1'b1, 16'hC000);
    #1 chk("pc_load_pri", pc_out, 16'hC000);

    // reset mid-run with pending increment
    cycle(1'b0, 1'b1, 1'b0, 2'd0, 16'h0000, 8'h00, 1'b1, 16'h8000);
    cycle(1'b1, 1'b1, 1'b1, 2'd0, 16'h0000, 8'h00, 1'b0, 16'h0000);
    #1 chk("pc_res_mid", pc_out, 16'h0000);
    chk("busy_res_mid", 16'(vector_busy), 16'h0001);

    // rdy_in low during VEC_HI
    vec_lo_byte = 8'hCD; vec_hi_byte = 8'hAB;
    idle(1'b1, 1'b0);
    repeat (3) begin
      c_en = 1; c_addr = 16'hFFFD; idle(1'b0, 1'b1);
    end
    #1 chk("pc_stall", pc_out, 16'h0000);
    idle(1'b1, 1'b0);
    #1 chk("pc_after_stall", pc_out, 16'hABCD);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bit r;
      r = ($urandom_range(0, 63) == 0);
      if (r) begin
        vec_lo_byte = 8'($urandom);
        vec_hi_byte = 8'($urandom);
      end
      cycle(r, ($urandom_range(0, 4) != 0), 1'($urandom), 2'($urandom),
            16'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0), 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
